snake_body_ctrl: RTL

- Owns the snake: holds head direction, body segment coordinates and length.
- Advances the snake one grid cell per move tick and drives Head_x/Head_y into the apple generator.
- Consumes that generator's Body_add_sig to grow the body, and flags wall and self collisions.
- Answers per-cell occupancy queries from the VGA renderer.

---
 rtl/snake_body_ctrl_if.sv | 11 +
 rtl/snake_body_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/snake_body_ctrl_if.sv
// Renderer-side occupancy query bus for the snake body controller.
// The renderer presents a cell and reads the registered hit/head flags one cycle later.
interface snake_body_ctrl_if;
  logic [5:0] Query_x;
  logic [4:0] Query_y;
  logic       Query_hit;
  logic       Query_head;

  modport master (output Query_x, Query_y, input Query_hit, Query_head);
  modport slave  (input Query_x, Query_y, output Query_hit, Query_head);
endinterface

// File: rtl/snake_body_ctrl.sv
// Snake body controller: direction latch, timed movement, growth, wall/self collision
// detection and a registered per-cell occupancy query for the renderer.
module snake_body_ctrl #(
  parameter int MOVE_TICKS = 12_500_000,
  parameter int MAX_LEN    = 16,
  parameter int X_MAX      = 39,
  parameter int Y_MAX      = 29
) (
  input  logic             Clk_50mhz,
  input  logic             Rst,
  input  logic             Start,
  input  logic [3:0]       Key_dir,
  input  logic             Body_add_sig,
  output logic [5:0]       Head_x,
  output logic [5:0]       Head_y,
  output logic [4:0]       Body_len,
  output logic             Move_pulse,
  output logic             Game_over,
  snake_body_ctrl_if.slave qry
);
  localparam int TW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  state_t        state;
  dir_t          dir;
  dir_t          next_dir;
  dir_t          key_d;
  logic          key_vld;
  logic          key_ok;
  logic [TW-1:0] tick;
  logic          grow_pend;
  logic          add_prev;
  logic [5:0]    seg_x [MAX_LEN];
  logic [4:0]    seg_y [MAX_LEN];
  logic [5:0]    nx;
  logic [4:0]    ny;
  logic [4:0]    self_lim;
  logic          self_hit;
  logic          wall_hit;
  logic          grow_now;
  logic          move_now;
  logic          add_edge;
  logic          restart;
  logic          q_hit;

  // Up/down and left/right differ only in the low bit of the encoding.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  always_comb begin
    key_vld = 1'b0;
    key_d   = D_RIGHT;
    case (Key_dir)
      4'b1000: begin key_vld = 1'b1; key_d = D_UP;    end
      4'b0100: begin key_vld = 1'b1; key_d = D_DOWN;  end
      4'b0010: begin key_vld = 1'b1; key_d = D_LEFT;  end
      4'b0001: begin key_vld = 1'b1; key_d = D_RIGHT; end
      default: ;
    endcase
    key_ok = key_vld && (key_d != reverse_dir(dir));
  end

  always_comb begin
    nx = seg_x[0];
    ny = seg_y[0];
    case (next_dir)
      D_UP:    ny = seg_y[0] - 5'd1;
      D_DOWN:  ny = seg_y[0] + 5'd1;
      D_LEFT:  nx = seg_x[0] - 6'd1;
      default: nx = seg_x[0] + 6'd1;
    endcase
  end

  assign wall_hit = (nx == 6'd0) || (nx == 6'(X_MAX)) || (ny == 5'd0) || (ny == 5'(Y_MAX));
  assign grow_now = grow_pend && (Body_len < 5'(MAX_LEN));
  assign move_now = (state == S_RUN) && (tick == TW'(MOVE_TICKS - 1));
  assign add_edge = Body_add_sig && !add_prev;
  assign restart  = (state == S_OVER) && Start;

  // Without growth the tail cell is vacated by this step, so it is excluded.
  always_comb begin
    self_lim = grow_now ? (Body_len - 5'd1) : (Body_len - 5'd2);
    self_hit = 1'b0;
    q_hit    = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) <= self_lim) && (seg_x[i] == nx) && (seg_y[i] == ny))
        self_hit = 1'b1;
      if ((5'(i) < Body_len) && (seg_x[i] == qry.Query_x) && (seg_y[i] == qry.Query_y))
        q_hit = 1'b1;
    end
  end

  always_ff @(posedge Clk_50mhz) begin
    if (Rst || restart) begin
      state          <= Rst ? S_IDLE : S_RUN;
      dir            <= D_RIGHT;
      next_dir       <= D_RIGHT;
      Body_len       <= 5'd3;
      tick           <= '0;
      grow_pend      <= 1'b0;
      add_prev       <= 1'b0;
      Move_pulse     <= 1'b0;
      Game_over      <= 1'b0;
      qry.Query_hit  <= 1'b0;
      qry.Query_head <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      seg_x[0] <= 6'd20; seg_y[0] <= 5'd15;
      seg_x[1] <= 6'd19; seg_y[1] <= 5'd15;
      seg_x[2] <= 6'd18; seg_y[2] <= 5'd15;
    end else begin
      Move_pulse     <= 1'b0;
      add_prev       <= Body_add_sig;
      qry.Query_hit  <= q_hit;
      qry.Query_head <= (seg_x[0] == qry.Query_x) && (seg_y[0] == qry.Query_y);
      case (state)
        S_IDLE: begin
          tick <= '0;
          if (Start) state <= S_RUN;
        end
        S_RUN: begin
          if (key_ok) next_dir <= key_d;
          if (move_now) begin
            tick       <= '0;
            Move_pulse <= 1'b1;
            if (wall_hit || self_hit) begin
              state     <= S_OVER;
              Game_over <= 1'b1;
            end else begin
              dir <= next_dir;
              for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
              end
              seg_x[0] <= nx;
              seg_y[0] <= ny;
              if (grow_now) Body_len <= Body_len + 5'd1;
              // A fresh request arriving on the consuming step stays pending.
              grow_pend <= add_edge;
            end
          end else begin
            tick <= tick + 1'b1;
            if (add_edge) grow_pend <= 1'b1;
          end
        end
        S_OVER: tick <= tick;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Head_x = seg_x[0];
  assign Head_y = {1'b0, seg_y[0]};
endmodule
